acc_file: RTL and testbench

- Accumulator register file that sits directly downstream of the ALU add/subtract stage.
- Holds two 56-bit accumulators, A and B, in ext:msb:lsb format.
- Captures the adder/subtractor sum, feeds the selected accumulator back as the adder's first operand, and derives condition flags.
- Moves accumulators onto the 24-bit data bus as a two-beat, optionally limited (saturated) transfer under a valid/ready handshake.

---
 rtl/acc_file_if.sv | 55 +++++
 rtl/acc_file.sv | 224 ++++++++++++++++++++++
 tb/tb_acc_file.sv | 601 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_file_if.sv
// ---------------------------------------------------------------------------
// acc_file_if
//
// Read-transfer channel of the accumulator file. A consumer raises rd_req
// (with rd_sel / rd_lim) to have one accumulator streamed out as two
// DATA_W-bit beats, msb word first, under a valid/ready handshake.
//
// Signals:
//   rd_req   consumer -> file   request a two-beat read
//   rd_sel   consumer -> file   source accumulator (0 = A, 1 = B)
//   rd_lim   consumer -> file   apply the limiter to this read
//   rd_ready consumer -> file   current beat is accepted
//   rd_valid file -> consumer   rd_data holds a beat
//   rd_data  file -> consumer   beat data
//   rd_last  file -> consumer   high on the lsb (final) beat
//   rd_busy  file -> consumer   a transfer is in progress
//
// Modports:
//   master  the consumer side (drives request and ready)
//   slave   the accumulator file (drives the beats)
// ---------------------------------------------------------------------------
interface acc_file_if #(
    parameter int DATA_W = 24
);
    logic              rd_req;
    logic              rd_sel;
    logic              rd_lim;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_busy;

    modport master (
        output rd_req,
        output rd_sel,
        output rd_lim,
        output rd_ready,
        input  rd_valid,
        input  rd_data,
        input  rd_last,
        input  rd_busy
    );

    modport slave (
        input  rd_req,
        input  rd_sel,
        input  rd_lim,
        input  rd_ready,
        output rd_valid,
        output rd_data,
        output rd_last,
        output rd_busy
    );
endinterface

// File: rtl/acc_file.sv
// ---------------------------------------------------------------------------
// acc_file
//
// Accumulator register file placed directly after the ALU add/subtract
// stage. Holds two accumulators A and B of width EXT_W + 2*DATA_W in
// ext:msb:lsb format, captures the adder result, feeds the selected
// accumulator back to the adder, derives condition flags and streams an
// accumulator onto the data bus as a two-beat, optionally saturated read.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   sum                 adder/subtractor result
//   alu_wr, alu_dst     write sum into A (0) or B (1)
//   src_sel, acc_out    combinational feedback of A (0) or B (1)
//   bw_en, bw_sel,
//   bw_data             bus write: sign-extended word into msb, lsb cleared
//   rd_bus              two-beat read channel (slave side)
//   flag_n/z/e/u        condition flags, updated on each ALU write
//   flag_l, l_clr       sticky limit flag and its clear
// ---------------------------------------------------------------------------
module acc_file #(
    parameter int DATA_W = 24,
    parameter int EXT_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [EXT_W+2*DATA_W-1:0]    sum,
    input  logic                         alu_wr,
    input  logic                         alu_dst,

    input  logic                         src_sel,
    output logic [EXT_W+2*DATA_W-1:0]    acc_out,

    input  logic                         bw_en,
    input  logic                         bw_sel,
    input  logic [DATA_W-1:0]            bw_data,

    acc_file_if.slave                    rd_bus,

    output logic                         flag_n,
    output logic                         flag_z,
    output logic                         flag_e,
    output logic                         flag_u,
    output logic                         flag_l,
    input  logic                         l_clr
);

    localparam int ACC_W  = EXT_W + 2 * DATA_W;
    localparam int MANT_W = 2 * DATA_W;
    // Bit index of the msb word's sign bit; ext bits above it must all
    // match it for the value to fit in the msb:lsb pair.
    localparam int SIGN_B = MANT_W - 1;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_HI,
        RD_LO
    } rd_state_t;

    // The value uses the extension byte when any ext bit differs from the
    // msb sign bit, i.e. the top EXT_W+1 bits are neither all 0 nor all 1.
    function automatic logic ext_in_use(input logic [ACC_W-1:0] v);
        logic [EXT_W:0] top;
        top = v[ACC_W-1:SIGN_B];
        return !((&top) || (~|top));
    endfunction

    logic [ACC_W-1:0]  acc_a;
    logic [ACC_W-1:0]  acc_b;
    logic [ACC_W-1:0]  acc_a_next;
    logic [ACC_W-1:0]  acc_b_next;
    logic [ACC_W-1:0]  bus_word;

    rd_state_t         rd_state;
    rd_state_t         rd_state_next;
    logic [MANT_W-1:0] snap;
    logic [MANT_W-1:0] snap_next;
    logic [ACC_W-1:0]  rd_src;
    logic              rd_accept;
    logic              lim_hit;

    // Feedback path to the adder: purely combinational, so a write shows
    // up on acc_out in the cycle after its clock edge.
    always_comb begin
        acc_out = src_sel ? acc_b : acc_a;
    end

    // A bus word lands in the msb position, sign-extended through ext.
    always_comb begin
        bus_word = {{EXT_W{bw_data[DATA_W-1]}}, bw_data, {DATA_W{1'b0}}};
    end

    // Write decode. The bus write is applied first and the ALU write second
    // so that, when both target the same accumulator, the ALU result wins.
    always_comb begin
        acc_a_next = acc_a;
        acc_b_next = acc_b;
        if (bw_en) begin
            if (bw_sel) begin
                acc_b_next = bus_word;
            end else begin
                acc_a_next = bus_word;
            end
        end
        if (alu_wr) begin
            if (alu_dst) begin
                acc_b_next = sum;
            end else begin
                acc_a_next = sum;
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_a <= '0;
            acc_b <= '0;
        end else begin
            acc_a <= acc_a_next;
            acc_b <= acc_b_next;
        end
    end

    // Condition flags follow the adder result and otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_e <= 1'b0;
            flag_u <= 1'b0;
        end else if (alu_wr) begin
            flag_n <= sum[ACC_W-1];
            flag_z <= (sum == '0);
            flag_e <= ext_in_use(sum);
            flag_u <= (sum[SIGN_B] == sum[SIGN_B-1]);
        end
    end

    // Read source and limiter. The registered (pre-write) value is used, so
    // a write landing in the request cycle does not reach the snapshot.
    always_comb begin
        rd_src    = rd_bus.rd_sel ? acc_b : acc_a;
        rd_accept = (rd_state == RD_IDLE) && rd_bus.rd_req;
        lim_hit   = rd_accept && rd_bus.rd_lim && ext_in_use(rd_src);
        snap_next = rd_src[MANT_W-1:0];
        if (rd_bus.rd_lim && ext_in_use(rd_src)) begin
            if (rd_src[ACC_W-1]) begin
                snap_next = {1'b1, {(MANT_W-1){1'b0}}};
            end else begin
                snap_next = {1'b0, {(MANT_W-1){1'b1}}};
            end
        end
    end

    // Sticky limit flag: a saturation in the same cycle as a clear keeps
    // the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_l <= 1'b0;
        end else if (lim_hit) begin
            flag_l <= 1'b1;
        end else if (l_clr) begin
            flag_l <= 1'b0;
        end
    end

    // Snapshot holding register, loaded only when a request is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap <= '0;
        end else if (rd_accept) begin
            snap <= snap_next;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_state_next;
        end
    end

    // Read FSM next state and outputs. Beats are driven straight from the
    // snapshot, so data and last stay stable while the consumer stalls.
    always_comb begin
        rd_state_next  = rd_state;
        rd_bus.rd_valid = 1'b0;
        rd_bus.rd_last  = 1'b0;
        rd_bus.rd_busy  = 1'b0;
        rd_bus.rd_data  = '0;
        case (rd_state)
            RD_IDLE: begin
                if (rd_bus.rd_req) begin
                    rd_state_next = RD_HI;
                end
            end
            RD_HI: begin
                rd_bus.rd_valid = 1'b1;
                rd_bus.rd_busy  = 1'b1;
                rd_bus.rd_data  = snap[MANT_W-1:DATA_W];
                if (rd_bus.rd_ready) begin
                    rd_state_next = RD_LO;
                end
            end
            RD_LO: begin
                rd_bus.rd_valid = 1'b1;
                rd_bus.rd_busy  = 1'b1;
                rd_bus.rd_last  = 1'b1;
                rd_bus.rd_data  = snap[DATA_W-1:0];
                if (rd_bus.rd_ready) begin
                    rd_state_next = RD_IDLE;
                end
            end
            default: begin
                rd_state_next = RD_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_acc_file.sv
// ---------------------------------------------------------------------------
// tb_acc_file
//
// Self-checking bench for acc_file. Each scenario task drives stimulus,
// pushes the beats it expects onto a queue and pops/compares them as the
// read channel produces them. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_acc_file;

    logic        clk;
    logic        reset;
    logic [55:0] sum;
    logic        alu_wr;
    logic        alu_dst;
    logic        src_sel;
    logic [55:0] acc_out;
    logic        bw_en;
    logic        bw_sel;
    logic [23:0] bw_data;
    logic        flag_n;
    logic        flag_z;
    logic        flag_e;
    logic        flag_u;
    logic        flag_l;
    logic        l_clr;

    acc_file_if #(.DATA_W(24)) rd_if ();

    acc_file #(.DATA_W(24), .EXT_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .sum     (sum),
        .alu_wr  (alu_wr),
        .alu_dst (alu_dst),
        .src_sel (src_sel),
        .acc_out (acc_out),
        .bw_en   (bw_en),
        .bw_sel  (bw_sel),
        .bw_data (bw_data),
        .rd_bus  (rd_if.slave),
        .flag_n  (flag_n),
        .flag_z  (flag_z),
        .flag_e  (flag_e),
        .flag_u  (flag_u),
        .flag_l  (flag_l),
        .l_clr   (l_clr)
    );

    int          checks;
    int          failures;
    logic [24:0] exp_q[$];
    logic [24:0] exp_beat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_acc(input logic dst, input logic [55:0] v);
        alu_wr  = 1'b1;
        alu_dst = dst;
        sum     = v;
        step();
        alu_wr  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        src_sel = 1'b0;
        #1;
        checks++;
        if (acc_out !== 56'h0) begin
            failures++;
            $display("[TB] FAIL reset_acc_a got=%h want=%h", acc_out, 56'h0);
        end
        src_sel = 1'b1;
        #1;
        checks++;
        if (acc_out !== 56'h0) begin
            failures++;
            $display("[TB] FAIL reset_acc_b got=%h want=%h", acc_out, 56'h0);
        end
        checks++;
        if ({flag_n, flag_z, flag_e, flag_u, flag_l} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b want=%b",
                     {flag_n, flag_z, flag_e, flag_u, flag_l}, 5'b0);
        end
        checks++;
        if ({rd_if.rd_valid, rd_if.rd_last, rd_if.rd_busy, rd_if.rd_data} !== 27'h0) begin
            failures++;
            $display("[TB] FAIL reset_read valid=%b last=%b busy=%b data=%h want all zero",
                     rd_if.rd_valid, rd_if.rd_last, rd_if.rd_busy, rd_if.rd_data);
        end
        src_sel = 1'b0;
    endtask

    task automatic test_alu_write();
        load_acc(1'b0, 56'h00_123456_789ABC);
        src_sel = 1'b0;
        #1;
        checks++;
        if (acc_out !== 56'h00_123456_789ABC) begin
            failures++;
            $display("[TB] FAIL alu_write_acc got=%h want=%h", acc_out, 56'h00_123456_789ABC);
        end
        checks++;
        if ({flag_n, flag_z, flag_e, flag_u} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL alu_write_flags nzeu got=%b want=%b",
                     {flag_n, flag_z, flag_e, flag_u}, 4'b0001);
        end
    endtask

    task automatic test_bus_write_read();
        int busy_cnt;
        bw_en   = 1'b1;
        bw_sel  = 1'b1;
        bw_data = 24'h800001;
        step();
        bw_en   = 1'b0;
        src_sel = 1'b1;
        #1;
        checks++;
        if (acc_out !== 56'hFF_800001_000000) begin
            failures++;
            $display("[TB] FAIL bus_write_acc got=%h want=%h", acc_out, 56'hFF_800001_000000);
        end
        checks++;
        if ({flag_n, flag_z, flag_e, flag_u} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL bus_write_flags_hold got=%b want=%b",
                     {flag_n, flag_z, flag_e, flag_u}, 4'b0001);
        end
        exp_q.push_back({1'b0, 24'h800001});
        exp_q.push_back({1'b1, 24'h000000});
        rd_if.rd_req   = 1'b1;
        rd_if.rd_sel   = 1'b1;
        rd_if.rd_lim   = 1'b0;
        rd_if.rd_ready = 1'b1;
        step();
        rd_if.rd_req = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rd_if.rd_busy) busy_cnt++;
            if (rd_if.rd_valid && rd_if.rd_ready && exp_q.size() != 0) begin
                exp_beat = exp_q.pop_front();
                checks++;
                if (rd_if.rd_data !== exp_beat[23:0] || rd_if.rd_last !== exp_beat[24]) begin
                    failures++;
                    $display("[TB] FAIL bus_read_beat got data=%h last=%b want data=%h last=%b",
                             rd_if.rd_data, rd_if.rd_last, exp_beat[23:0], exp_beat[24]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL bus_read_timeout beats_left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (busy_cnt != 2) begin
            failures++;
            $display("[TB] FAIL bus_read_busy_cycles got=%0d want=2", busy_cnt);
        end
        step();
    endtask

    task automatic test_limiter();
        // Positive overflow saturates to the largest msb:lsb value.
        load_acc(1'b0, 56'h01_000000_000000);
        exp_q.push_back({1'b0, 24'h7FFFFF});
        exp_q.push_back({1'b1, 24'hFFFFFF});
        rd_if.rd_req   = 1'b1;
        rd_if.rd_sel   = 1'b0;
        rd_if.rd_lim   = 1'b1;
        rd_if.rd_ready = 1'b1;
        step();
        rd_if.rd_req = 1'b0;
        rd_if.rd_lim = 1'b0;
        checks++;
        if (flag_l !== 1'b1) begin
            failures++;
            $display("[TB] FAIL limit_pos_flag_l got=%b want=1", flag_l);
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                exp_beat = exp_q.pop_front();
                checks++;
                if (rd_if.rd_data !== exp_beat[23:0] || rd_if.rd_last !== exp_beat[24]) begin
                    failures++;
                    $display("[TB] FAIL limit_pos_beat got data=%h last=%b want data=%h last=%b",
                             rd_if.rd_data, rd_if.rd_last, exp_beat[23:0], exp_beat[24]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL limit_pos_timeout beats_left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        step();

        // Negative overflow saturates to the most negative value; a clear
        // in the same cycle as a saturation leaves the flag set.
        load_acc(1'b0, 56'hFE_000000_000000);
        exp_q.push_back({1'b0, 24'h800000});
        exp_q.push_back({1'b1, 24'h000000});
        rd_if.rd_req = 1'b1;
        rd_if.rd_lim = 1'b1;
        l_clr        = 1'b1;
        step();
        rd_if.rd_req = 1'b0;
        rd_if.rd_lim = 1'b0;
        l_clr        = 1'b0;
        checks++;
        if (flag_l !== 1'b1) begin
            failures++;
            $display("[TB] FAIL limit_set_beats_clear got=%b want=1", flag_l);
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                exp_beat = exp_q.pop_front();
                checks++;
                if (rd_if.rd_data !== exp_beat[23:0] || rd_if.rd_last !== exp_beat[24]) begin
                    failures++;
                    $display("[TB] FAIL limit_neg_beat got data=%h last=%b want data=%h last=%b",
                             rd_if.rd_data, rd_if.rd_last, exp_beat[23:0], exp_beat[24]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL limit_neg_timeout beats_left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        step();

        l_clr = 1'b1;
        step();
        l_clr = 1'b0;
        checks++;
        if (flag_l !== 1'b0) begin
            failures++;
            $display("[TB] FAIL limit_clear got=%b want=0", flag_l);
        end

        // In-range value passes through the limiter untouched.
        load_acc(1'b0, 56'h00_400000_000001);
        exp_q.push_back({1'b0, 24'h400000});
        exp_q.push_back({1'b1, 24'h000001});
        rd_if.rd_req = 1'b1;
        rd_if.rd_lim = 1'b1;
        step();
        rd_if.rd_req = 1'b0;
        rd_if.rd_lim = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                exp_beat = exp_q.pop_front();
                checks++;
                if (rd_if.rd_data !== exp_beat[23:0] || rd_if.rd_last !== exp_beat[24]) begin
                    failures++;
                    $display("[TB] FAIL limit_pass_beat got data=%h last=%b want data=%h last=%b",
                             rd_if.rd_data, rd_if.rd_last, exp_beat[23:0], exp_beat[24]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL limit_pass_timeout beats_left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (flag_l !== 1'b0) begin
            failures++;
            $display("[TB] FAIL limit_pass_flag_l got=%b want=0", flag_l);
        end
        step();
    endtask

    task automatic test_backpressure();
        load_acc(1'b0, 56'h00_111111_222222);
        exp_q.push_back({1'b0, 24'h111111});
        exp_q.push_back({1'b1, 24'h222222});
        rd_if.rd_req   = 1'b1;
        rd_if.rd_sel   = 1'b0;
        rd_if.rd_lim   = 1'b0;
        rd_if.rd_ready = 1'b0;
        step();
        // Overwrite the source and re-request while the first beat stalls.
        alu_wr  = 1'b1;
        alu_dst = 1'b0;
        sum     = 56'h00_AAAAAA_BBBBBB;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 24'h111111 || rd_if.rd_last !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stall_hold cycle=%0d got valid=%b data=%h last=%b want valid=1 data=111111 last=0",
                         c, rd_if.rd_valid, rd_if.rd_data, rd_if.rd_last);
            end
            step();
            alu_wr = 1'b0;
        end
        rd_if.rd_req   = 1'b0;
        rd_if.rd_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                exp_beat = exp_q.pop_front();
                checks++;
                if (rd_if.rd_data !== exp_beat[23:0] || rd_if.rd_last !== exp_beat[24]) begin
                    failures++;
                    $display("[TB] FAIL stall_snapshot_beat got data=%h last=%b want data=%h last=%b",
                             rd_if.rd_data, rd_if.rd_last, exp_beat[23:0], exp_beat[24]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL stall_timeout beats_left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        step();
        checks++;
        if (rd_if.rd_busy !== 1'b0 || rd_if.rd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_req_ignored got busy=%b valid=%b want busy=0 valid=0",
                     rd_if.rd_busy, rd_if.rd_valid);
        end
        src_sel = 1'b0;
        #1;
        checks++;
        if (acc_out !== 56'h00_AAAAAA_BBBBBB) begin
            failures++;
            $display("[TB] FAIL stall_write_landed got=%h want=%h", acc_out, 56'h00_AAAAAA_BBBBBB);
        end
    endtask

    task automatic test_write_priority();
        // Same accumulator: the ALU result wins.
        alu_wr  = 1'b1;
        alu_dst = 1'b0;
        sum     = 56'h5;
        bw_en   = 1'b1;
        bw_sel  = 1'b0;
        bw_data = 24'h000007;
        step();
        alu_wr  = 1'b0;
        bw_en   = 1'b0;
        src_sel = 1'b0;
        #1;
        checks++;
        if (acc_out !== 56'h5) begin
            failures++;
            $display("[TB] FAIL write_same_acc got=%h want=%h", acc_out, 56'h5);
        end

        // Different accumulators: both land.
        alu_wr  = 1'b1;
        alu_dst = 1'b0;
        sum     = 56'h9;
        bw_en   = 1'b1;
        bw_sel  = 1'b1;
        bw_data = 24'h000007;
        step();
        alu_wr  = 1'b0;
        bw_en   = 1'b0;
        src_sel = 1'b0;
        #1;
        checks++;
        if (acc_out !== 56'h9) begin
            failures++;
            $display("[TB] FAIL write_both_a got=%h want=%h", acc_out, 56'h9);
        end
        src_sel = 1'b1;
        #1;
        checks++;
        if (acc_out !== 56'h00_000007_000000) begin
            failures++;
            $display("[TB] FAIL write_both_b got=%h want=%h", acc_out, 56'h00_000007_000000);
        end

        load_acc(1'b0, 56'h0);
        checks++;
        if ({flag_n, flag_z, flag_e, flag_u} !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL flags_zero nzeu got=%b want=%b", {flag_n, flag_z, flag_e, flag_u}, 4'b0101);
        end

        load_acc(1'b1, 56'h80_000000_000000);
        checks++;
        if ({flag_n, flag_z, flag_e, flag_u} !== 4'b1011) begin
            failures++;
            $display("[TB] FAIL flags_neg_ext nzeu got=%b want=%b", {flag_n, flag_z, flag_e, flag_u}, 4'b1011);
        end

        load_acc(1'b1, 56'h00_800000_000000);
        checks++;
        if ({flag_n, flag_z, flag_e, flag_u} !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL flags_unnorm nzeu got=%b want=%b", {flag_n, flag_z, flag_e, flag_u}, 4'b0010);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] busy_seen;
        load_acc(1'b0, 56'h00_A5A5A5_5A5A5A);
        load_acc(1'b1, 56'h00_0F0F0F_F0F0F0);
        exp_q.push_back({1'b0, 24'hA5A5A5});
        exp_q.push_back({1'b1, 24'h5A5A5A});
        exp_q.push_back({1'b0, 24'h0F0F0F});
        exp_q.push_back({1'b1, 24'hF0F0F0});
        rd_if.rd_req   = 1'b1;
        rd_if.rd_sel   = 1'b0;
        rd_if.rd_lim   = 1'b0;
        rd_if.rd_ready = 1'b1;
        step();
        rd_if.rd_sel = 1'b1;
        busy_seen = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            busy_seen[c] = rd_if.rd_busy;
            if (rd_if.rd_valid && rd_if.rd_ready && exp_q.size() != 0) begin
                exp_beat = exp_q.pop_front();
                checks++;
                if (rd_if.rd_data !== exp_beat[23:0] || rd_if.rd_last !== exp_beat[24]) begin
                    failures++;
                    $display("[TB] FAIL b2b_beat got data=%h last=%b want data=%h last=%b",
                             rd_if.rd_data, rd_if.rd_last, exp_beat[23:0], exp_beat[24]);
                end
            end
            if (c == 3) rd_if.rd_req = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL b2b_timeout beats_left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (busy_seen !== 6'b011011) begin
            failures++;
            $display("[TB] FAIL b2b_busy_pattern got=%b want=%b", busy_seen, 6'b011011);
        end
        step();
    endtask

    task automatic test_reset_mid_transfer();
        load_acc(1'b1, 56'h00_ABCDEF_123456);
        load_acc(1'b0, 56'h80_000000_000000);
        exp_q.push_back({1'b0, 24'h800000});
        rd_if.rd_req   = 1'b1;
        rd_if.rd_sel   = 1'b0;
        rd_if.rd_lim   = 1'b1;
        rd_if.rd_ready = 1'b0;
        step();
        rd_if.rd_req   = 1'b0;
        rd_if.rd_lim   = 1'b0;
        rd_if.rd_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                exp_beat = exp_q.pop_front();
                checks++;
                if (rd_if.rd_data !== exp_beat[23:0] || rd_if.rd_last !== exp_beat[24]) begin
                    failures++;
                    $display("[TB] FAIL mid_reset_hi_beat got data=%h last=%b want data=%h last=%b",
                             rd_if.rd_data, rd_if.rd_last, exp_beat[23:0], exp_beat[24]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL mid_reset_hi_timeout beats_left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        step();
        rd_if.rd_ready = 1'b0;
        checks++;
        if (rd_if.rd_valid !== 1'b1 || rd_if.rd_last !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_reset_in_lo got valid=%b last=%b want valid=1 last=1",
                     rd_if.rd_valid, rd_if.rd_last);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({rd_if.rd_valid, rd_if.rd_busy, rd_if.rd_last, rd_if.rd_data} !== 27'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset_read valid=%b busy=%b last=%b data=%h want all zero",
                     rd_if.rd_valid, rd_if.rd_busy, rd_if.rd_last, rd_if.rd_data);
        end
        checks++;
        if ({flag_n, flag_z, flag_e, flag_u, flag_l} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_flags got=%b want=%b", {flag_n, flag_z, flag_e, flag_u, flag_l}, 5'b0);
        end
        src_sel = 1'b0;
        #1;
        checks++;
        if (acc_out !== 56'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset_acc_a got=%h want=%h", acc_out, 56'h0);
        end
        src_sel = 1'b1;
        #1;
        checks++;
        if (acc_out !== 56'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset_acc_b got=%h want=%h", acc_out, 56'h0);
        end
        exp_q.push_back({1'b0, 24'h000000});
        exp_q.push_back({1'b1, 24'h000000});
        rd_if.rd_req   = 1'b1;
        rd_if.rd_sel   = 1'b1;
        rd_if.rd_ready = 1'b1;
        step();
        rd_if.rd_req = 1'b0;
        checks++;
        if (rd_if.rd_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset_accept busy got=%b want=1", rd_if.rd_busy);
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                exp_beat = exp_q.pop_front();
                checks++;
                if (rd_if.rd_data !== exp_beat[23:0] || rd_if.rd_last !== exp_beat[24]) begin
                    failures++;
                    $display("[TB] FAIL post_reset_beat got data=%h last=%b want data=%h last=%b",
                             rd_if.rd_data, rd_if.rd_last, exp_beat[23:0], exp_beat[24]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL post_reset_timeout beats_left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        step();
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        sum            = '0;
        alu_wr         = 1'b0;
        alu_dst        = 1'b0;
        src_sel        = 1'b0;
        bw_en          = 1'b0;
        bw_sel         = 1'b0;
        bw_data        = '0;
        l_clr          = 1'b0;
        rd_if.rd_req   = 1'b0;
        rd_if.rd_sel   = 1'b0;
        rd_if.rd_lim   = 1'b0;
        rd_if.rd_ready = 1'b0;

        test_reset();
        test_alu_write();
        test_bus_write_read();
        test_limiter();
        test_backpressure();
        test_write_priority();
        test_back_to_back();
        test_reset_mid_transfer();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
